pixel_pingpong_bank: RTL and testbench
======================================

PIXEL_PINGPONG_BANK -- requirements
Module: pixel_pingpong_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bits per pixel word.
REQ-002 SHALL have parameter N_LANES, default 4, parallel pixel lanes per beat.
REQ-003 SHALL have parameter DEPTH, default 32, beats per bank (DEPTH >= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid  input  1  write beat offered.
REQ-007 SHALL have port wr_ready  output  1  write bank can accept a beat.
REQ-008 SHALL have port wr_data  input  N_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port rd_valid  output  1  read bank holds an unread beat.
REQ-010 SHALL have port rd_ready  input  1  consumer takes the beat.
REQ-011 SHALL have port rd_data  output  N_LANES*DATA_W  beat at the current read address.
REQ-012 SHALL have port wr_bank  output  1  bank selected for writing.
REQ-013 SHALL have port rd_bank  output  1  bank selected for reading.
REQ-014 SHALL have port full_cnt  output  2  number of banks in FULL or DRAINING (0..2).

Function
REQ-015 SHALL hold two banks, each DEPTH beats of N_LANES*DATA_W bits.
REQ-016 SHALL run a per-bank FSM with states EMPTY, FILLING, FULL and DRAINING.
REQ-017 Write fire = wr_valid && wr_ready; it SHALL store wr_data at [wr_bank][wr_addr] and increment wr_addr.
REQ-018 wr_ready SHALL be 1 iff the state of wr_bank is EMPTY or FILLING.
REQ-019 Transitions: EMPTY->FILLING on a write fire; on the fire at wr_addr == DEPTH-1 the bank SHALL go to FULL, wr_addr SHALL go to 0 and wr_bank SHALL toggle.
REQ-020 Read fire = rd_valid && rd_ready; rd_valid SHALL be 1 iff the state of rd_bank is FULL or DRAINING.
REQ-021 Transitions: FULL->DRAINING on a read fire; on the fire at rd_addr == DEPTH-1 the bank SHALL go to EMPTY, rd_addr SHALL go to 0 and rd_bank SHALL toggle.
REQ-022 If DEPTH == 1, EMPTY SHALL go directly to FULL and FULL directly to EMPTY.
REQ-023 rd_data SHALL be combinational from [rd_bank][rd_addr] (zero-latency read); it is defined only while rd_valid is 1.
REQ-024 A beat written in cycle N SHALL be readable no earlier than cycle N+1 after its bank reaches FULL.
REQ-025 When both banks are full, wr_ready SHALL be 0 and wr_data SHALL be ignored (backpressure, no overwrite).
REQ-026 When both banks are empty, rd_valid SHALL be 0.
REQ-027 A write fire and a read fire in the same cycle (always on different banks) SHALL both take effect, including simultaneous bank completions.
REQ-028 full_cnt SHALL be registered-state derived and update the cycle after a completing fire.
REQ-029 Address counters SHALL be $clog2(DEPTH) bits wide (minimum 1) and SHALL wrap only via REQ-019 and REQ-021.

Reset
REQ-030 On rst, both banks SHALL enter EMPTY, and wr_addr, rd_addr, wr_bank and rd_bank SHALL be 0.
REQ-031 After rst, wr_ready SHALL be 1, rd_valid 0 and full_cnt 0; storage contents SHALL NOT be reset.
REQ-032 rst asserted mid-fill or mid-drain SHALL abandon the partial data with no further handshakes.

Configuration
REQ-033 Macro PIXBANK_FLUSH_EN, when defined, SHALL add port flush (input, 1): a synchronous flush with the same effect as REQ-030/031 at the next edge, taking priority over any concurrent fire.
REQ-034 Without PIXBANK_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
REQ-035 Package pixbank_pkg SHALL hold the bank_state_t enum (EMPTY, FILLING, FULL, DRAINING) and the parameter defaults.
REQ-036 Sub-module pixbank_mem SHALL implement one bank: one synchronous write port and one asynchronous read port, instantiated twice.

Verification (bench DEPTH=4, N_LANES=4, DATA_W=32)
REQ-037 Reset, then 4 write beats 0x01..0x04 -> bank0 FULL, wr_bank=1, full_cnt=1, rd_valid=1, rd_data=0x01 per lane.
REQ-038 8 writes with rd_ready=0, then a 9th wr_valid -> wr_ready=0 after the 8th beat, full_cnt=2, 9th beat not stored.
REQ-039 Drain 8 beats with rd_ready=1 -> data order 1..8, rd_bank toggles after beat 4, rd_valid=0 and full_cnt=0 at the end.
REQ-040 Continuous wr_valid=1 and rd_ready=1 for 40 beats -> in-order data, no loss, full_cnt never exceeds 2.
REQ-041 rst asserted after 2 writes -> wr_ready=1, rd_valid=0, and the next 4 writes appear at rd_addr 0..3.
REQ-042 With PIXBANK_FLUSH_EN: flush in the same cycle as a bank-completing write -> full_cnt=0 and the bank stays EMPTY.

Source files
------------

// File: rtl/pixbank_pkg.sv
// Shared types and defaults for the two-bank pixel ping-pong buffer.
package pixbank_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int N_LANES_DEF = 4;
  localparam int DEPTH_DEF   = 32;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pixbank_mem.sv
// One storage bank: synchronous write port, asynchronous (zero-latency) read port.
module pixbank_mem
  import pixbank_pkg::*;
#(
  parameter int WORD_W = DATA_W_DEF * N_LANES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_pingpong_bank.sv
// Two-bank ping-pong pixel buffer: one bank fills while the other drains.
// Optional macro PIXBANK_FLUSH_EN adds a synchronous flush input.
module pixel_pingpong_bank
  import pixbank_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_LANES = N_LANES_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef PIXBANK_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [N_LANES*DATA_W-1:0] wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [N_LANES*DATA_W-1:0] rd_data,
  output logic                      wr_bank,
  output logic                      rd_bank,
  output logic [1:0]                full_cnt
);

  localparam int            AW     = addr_w(DEPTH);
  localparam int            WORD_W = N_LANES * DATA_W;
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  bank_state_t       st_q [2];
  bank_state_t       st_d [2];
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_fire, rd_fire;
  logic [WORD_W-1:0] rdata0, rdata1;

  assign wr_ready = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
  assign rd_valid = (st_q[rd_bank_q] == FULL)  || (st_q[rd_bank_q] == DRAINING);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign rd_data  = rd_bank_q ? rdata1 : rdata0;

  always_comb begin
    full_cnt = 2'd0;
    for (int b = 0; b < 2; b++) begin
      if (st_q[b] == FULL || st_q[b] == DRAINING) full_cnt = full_cnt + 2'd1;
    end
  end

  // Write and read always target different banks, so both updates can apply in one cycle.
  always_comb begin
    st_d      = st_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      if (wr_addr_q == LAST) begin
        st_d[wr_bank_q] = FULL;
        wr_addr_d       = '0;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        st_d[wr_bank_q] = FILLING;
        wr_addr_d       = wr_addr_q + AW'(1);
      end
    end
    if (rd_fire) begin
      if (rd_addr_q == LAST) begin
        st_d[rd_bank_q] = EMPTY;
        rd_addr_d       = '0;
        rd_bank_d       = ~rd_bank_q;
      end else begin
        st_d[rd_bank_q] = DRAINING;
        rd_addr_d       = rd_addr_q + AW'(1);
      end
    end
`ifdef PIXBANK_FLUSH_EN
    if (flush) begin
      st_d[0]   = EMPTY;
      st_d[1]   = EMPTY;
      wr_addr_d = '0;
      rd_addr_d = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  pixbank_mem #(.WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_mem0 (
    .clk     (clk),
    .we_i    (wr_fire && !wr_bank_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata0)
  );

  pixbank_mem #(.WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_mem1 (
    .clk     (clk),
    .we_i    (wr_fire && wr_bank_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata1)
  );

endmodule

// File: tb/tb_pixel_pingpong_bank.sv
// Scoreboard bench for pixel_pingpong_bank (DEPTH=4, N_LANES=4, DATA_W=32).
module tb_pixel_pingpong_bank;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int DP = 4;
  localparam int W  = NL * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         rd_ready = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready, rd_valid, wr_bank, rd_bank;
  logic [1:0]   full_cnt;
  logic [W-1:0] rd_data;
`ifdef PIXBANK_FLUSH_EN
  logic         flush = 1'b0;
`endif

  pixel_pingpong_bank #(.DATA_W(DW), .N_LANES(NL), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PIXBANK_FLUSH_EN
    .flush    (flush),
`endif
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .full_cnt (full_cnt)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_read   = 0;
  int           max_fc   = 0;

  // Reference model: beats accumulate per bank; a bank becomes readable once DP beats arrive.
  logic [W-1:0] exp_q [$];
  logic [W-1:0] part_q [$];
  int           m_nfull = 0;
  int           m_rcnt  = 0;
  bit           m_wbank = 1'b0;
  bit           m_rbank = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  always @(posedge clk) begin : model
    bit wf, rf, clr;
    clr = rst;
`ifdef PIXBANK_FLUSH_EN
    clr = clr || flush;
`endif
    if (clr) begin
      exp_q.delete();
      part_q.delete();
      m_nfull = 0;
      m_rcnt  = 0;
      m_wbank = 1'b0;
      m_rbank = 1'b0;
    end else begin
      wf = wr_valid && (m_nfull < 2);
      rf = rd_ready && (m_nfull > 0);
      if (rf) begin
        m_rcnt++;
        if (m_rcnt == DP) begin
          m_rcnt  = 0;
          m_nfull--;
          m_rbank = ~m_rbank;
        end
      end
      if (wf) begin
        part_q.push_back(wr_data);
        if (part_q.size() == DP) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          m_nfull++;
          m_wbank = ~m_wbank;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rst) begin
      chk("wr_ready", W'(wr_ready), W'(m_nfull < 2));
      chk("rd_valid", W'(rd_valid), W'(m_nfull > 0));
      chk("full_cnt", W'(full_cnt), W'(m_nfull));
      chk("wr_bank", W'(wr_bank), W'(m_wbank));
      chk("rd_bank", W'(rd_bank), W'(m_rbank));
      if (int'(full_cnt) > max_fc) max_fc = int'(full_cnt);
      if (rd_valid && rd_ready) begin
        n_read++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_extra: read %0h but no beat expected", rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  task automatic step(input bit wv, input logic [W-1:0] d, input bit rr);
    wr_valid = wv;
    wr_data  = d;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (rd_valid && k < 40) begin
      step(1'b0, '0, 1'b1);
      k++;
    end
    chk("drain_done", W'(rd_valid), W'(0));
    step(1'b0, '0, 1'b0);
  endtask

  task automatic pulse_rst();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int rd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wr_ready", W'(wr_ready), W'(1));
    chk("rst_rd_valid", W'(rd_valid), W'(0));
    chk("rst_full_cnt", W'(full_cnt), W'(0));
    chk("rst_banks", W'({wr_bank, rd_bank}), W'(0));

    // First bank fill
    for (int i = 1; i <= 4; i++) step(1'b1, rep(DW'(i)), 1'b0);
    chk("fill_full_cnt", W'(full_cnt), W'(1));
    chk("fill_wr_bank", W'(wr_bank), W'(1));
    chk("fill_rd_valid", W'(rd_valid), W'(1));
    chk("fill_rd_data", rd_data, rep(32'h1));

    // Both banks full, then backpressure on a ninth beat
    for (int i = 5; i <= 8; i++) step(1'b1, rep(DW'(i)), 1'b0);
    chk("bp_wr_ready", W'(wr_ready), W'(0));
    chk("bp_full_cnt", W'(full_cnt), W'(2));
    step(1'b1, rep(32'h9), 1'b0);
    step(1'b1, rep(32'h9), 1'b0);
    chk("bp_hold_wr_ready", W'(wr_ready), W'(0));
    chk("bp_hold_rd_data", rd_data, rep(32'h1));

    // Drain eight beats
    rd0 = n_read;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("drain_rd_bank", W'(rd_bank), W'(1));
    chk("drain_second_bank_data", rd_data, rep(32'h5));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("drain_end_rd_valid", W'(rd_valid), W'(0));
    chk("drain_end_full_cnt", W'(full_cnt), W'(0));
    chk("drain_count", W'(n_read - rd0), W'(8));
    step(1'b0, '0, 1'b0);

    // Reset mid-fill abandons partial data
    step(1'b1, rep(32'hA1), 1'b0);
    step(1'b1, rep(32'hA2), 1'b0);
    pulse_rst();
    chk("midrst_wr_ready", W'(wr_ready), W'(1));
    chk("midrst_rd_valid", W'(rd_valid), W'(0));
    chk("midrst_full_cnt", W'(full_cnt), W'(0));
    for (int i = 1; i <= 4; i++) step(1'b1, rep(DW'(32'hB0 + i)), 1'b0);
    chk("midrst_first_beat", rd_data, rep(32'hB1));
    drain();

    // Continuous streaming
    rd0 = n_read;
    for (int i = 0; i < 40; i++) step(1'b1, rep(DW'(32'h100 + i)), 1'b1);
    drain();
    chk("stream_count", W'(n_read - rd0), W'(40));
    chk("stream_max_full_cnt", W'(max_fc <= 2), W'(1));

    // Randomized traffic with varying read pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 3) < ph + 1));
      end
    end
    drain();
    chk("rand_full_cnt_end", W'(full_cnt), W'(0));

`ifdef PIXBANK_FLUSH_EN
    pulse_rst();
    for (int i = 1; i <= 3; i++) step(1'b1, rep(DW'(32'hC0 + i)), 1'b0);
    flush = 1'b1;
    step(1'b1, rep(32'hC4), 1'b0);
    flush = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("flush_full_cnt", W'(full_cnt), W'(0));
    chk("flush_rd_valid", W'(rd_valid), W'(0));
    chk("flush_wr_ready", W'(wr_ready), W'(1));
    chk("flush_wr_bank", W'(wr_bank), W'(0));
`endif

    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
